// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA mode constants and coordinate width shared by the timing generator
package vga_timing_pkg;

  localparam int COORD_W = 11;

  // 640x480@60, pixel rate 25.175 MHz
  localparam int          M640_H_ACTIVE = 640;
  localparam int          M640_H_FP     = 16;
  localparam int          M640_H_SYNC   = 96;
  localparam int          M640_H_BP     = 48;
  localparam int          M640_V_ACTIVE = 480;
  localparam int          M640_V_FP     = 10;
  localparam int          M640_V_SYNC   = 2;
  localparam int          M640_V_BP     = 33;
  localparam logic        M640_HS_POL   = 1'b0;
  localparam logic        M640_VS_POL   = 1'b0;
  localparam int unsigned M640_STB_INC  = 16499;

  // 1024x768@60, pixel rate 65.0 MHz
  localparam int          M1024_H_ACTIVE = 1024;
  localparam int          M1024_H_FP     = 24;
  localparam int          M1024_H_SYNC   = 136;
  localparam int          M1024_H_BP     = 160;
  localparam int          M1024_V_ACTIVE = 768;
  localparam int          M1024_V_FP     = 3;
  localparam int          M1024_V_SYNC   = 6;
  localparam int          M1024_V_BP     = 29;
  localparam logic        M1024_HS_POL   = 1'b0;
  localparam logic        M1024_VS_POL   = 1'b0;
  localparam int unsigned M1024_STB_INC  = 42598;

endpackage

// File: rtl/pix_stb_gen.sv
// rtl/pix_stb_gen.sv - fractional pixel strobe from a phase accumulator
module pix_stb_gen #(
  parameter int          ACC_W   = 16,
  parameter int unsigned STB_INC = 42598
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_stb,
  output logic o_carry
);

  generate
    if (STB_INC < 1 || STB_INC > (2 ** ACC_W)) begin : g_bad_inc
      $error("pix_stb_gen: STB_INC out of range 1..2^ACC_W");
    end
  endgenerate

  localparam logic [ACC_W:0] INC = (ACC_W + 1)'(STB_INC);

  logic [ACC_W:0] acc;
  logic [ACC_W:0] acc_nxt;

  assign acc_nxt = {1'b0, acc[ACC_W-1:0]} + INC;
  // o_carry is the carry being registered on this edge; the raster advances with it
  assign o_carry = acc_nxt[ACC_W];
  assign o_stb   = acc[ACC_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TIMING_FRAME_CNT_EN enables o_frame counting
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int          H_ACTIVE = M1024_H_ACTIVE,
  parameter int          H_FP     = M1024_H_FP,
  parameter int          H_SYNC   = M1024_H_SYNC,
  parameter int          H_BP     = M1024_H_BP,
  parameter int          V_ACTIVE = M1024_V_ACTIVE,
  parameter int          V_FP     = M1024_V_FP,
  parameter int          V_SYNC   = M1024_V_SYNC,
  parameter int          V_BP     = M1024_V_BP,
  parameter logic        HS_POL   = M1024_HS_POL,
  parameter logic        VS_POL   = M1024_VS_POL,
  parameter int          ACC_W    = 16,
  parameter int unsigned STB_INC  = M1024_STB_INC
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_pix_stb,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_active,
  output logic               o_screenend,
  output logic               o_animate,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [15:0]        o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_mode
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_ACT_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic               stb_carry;
  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;
  logic               end_nxt;
  logic               anim_nxt;

  pix_stb_gen #(
    .ACC_W   (ACC_W),
    .STB_INC (STB_INC)
  ) u_pix_stb_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_stb   (o_pix_stb),
    .o_carry (stb_carry)
  );

  always_comb begin
    h_nxt = o_x + COORD_W'(1);
    v_nxt = o_y;
    if (o_x == H_LAST) begin
      h_nxt = '0;
      v_nxt = (o_y == V_LAST) ? '0 : o_y + COORD_W'(1);
    end
    end_nxt  = (h_nxt == H_LAST) && (v_nxt == V_LAST);
    anim_nxt = (h_nxt == H_ACT_LAST) && (v_nxt == V_ACT_LAST);
  end

  // Reset parks the raster on the last pixel so the first strobe lands on (0,0)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x         <= H_LAST;
      o_y         <= V_LAST;
      o_active    <= 1'b0;
      o_hs        <= ~HS_POL;
      o_vs        <= ~VS_POL;
      o_screenend <= 1'b0;
      o_animate   <= 1'b0;
    end else if (stb_carry) begin
      o_x         <= h_nxt;
      o_y         <= v_nxt;
      o_active    <= (h_nxt <= H_ACT_LAST) && (v_nxt <= V_ACT_LAST);
      o_hs        <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
      o_vs        <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
      o_screenend <= end_nxt;
      o_animate   <= anim_nxt;
    end else begin
      o_screenend <= 1'b0;
      o_animate   <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame <= '0;
    end else if (stb_carry && end_nxt) begin
      o_frame <= o_frame + 16'd1;
    end
  end
`else
  assign o_frame = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced 16x10 raster
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3, HT = 16;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1, VT = 10;
  localparam int FRAME = HT * VT;
  localparam longint INC_A = 65536;
  localparam longint INC_B = 42598;

  typedef struct packed {
    logic        stb;
    logic        hs;
    logic        vs;
    logic        active;
    logic        se;
    logic        an;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] frame;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_stb, a_hs, a_vs, a_active, a_se, a_an;
  logic [10:0] a_x, a_y;
  logic [15:0] a_frame;
  logic        b_stb, b_hs, b_vs, b_active, b_se, b_an;
  logic [10:0] b_x, b_y;
  logic [15:0] b_frame;
  obs_t        got_a, got_b;

  assign got_a = {a_stb, a_hs, a_vs, a_active, a_se, a_an, a_x, a_y, a_frame};
  assign got_b = {b_stb, b_hs, b_vs, b_active, b_se, b_an, b_x, b_y, b_frame};

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .ACC_W(16), .STB_INC(65536)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_stb(a_stb), .o_hs(a_hs), .o_vs(a_vs),
    .o_active(a_active), .o_screenend(a_se), .o_animate(a_an),
    .o_x(a_x), .o_y(a_y), .o_frame(a_frame)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .ACC_W(16), .STB_INC(42598)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_stb(b_stb), .o_hs(b_hs), .o_vs(b_vs),
    .o_active(b_active), .o_screenend(b_se), .o_animate(b_an),
    .o_x(b_x), .o_y(b_y), .o_frame(b_frame)
  );

  int n_cmp = 0;
  int n_bad = 0;
  longint n_edge = 0;
  obs_t qa[$];
  obs_t qb[$];
  int se_cnt = 0;
  int an_cnt = 0;

  // Expected outputs after the n-th edge since release: s = floor(n*inc/2^16) strobes so far
  function automatic obs_t model(longint n, longint inc);
    obs_t o;
    longint s, sp, p, x, y;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.x = 11'(HT - 1);
    o.y = 11'(VT - 1);
    if (n > 0) begin
      s  = (n * inc) >>> 16;
      sp = ((n - 1) * inc) >>> 16;
      o.stb = (s != sp);
      if (s > 0) begin
        p = s - 1;
        x = p % HT;
        y = (p / HT) % VT;
        o.x = 11'(x);
        o.y = 11'(y);
        o.active = (x < HA) && (y < VA);
        o.hs = !(x >= HA + HFP && x < HA + HFP + HS);
        o.vs = !(y >= VA + VFP && y < VA + VFP + VS);
        o.se = o.stb && (x == HT - 1) && (y == VT - 1);
        o.an = o.stb && (x == HA - 1) && (y == VA - 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.frame = 16'(s / FRAME);
`endif
      end
    end
    return o;
  endfunction

  task automatic check_obs(string name, obs_t got, obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got stb=%b hs=%b vs=%b act=%b se=%b an=%b x=%0d y=%0d fr=%0d want stb=%b hs=%b vs=%b act=%b se=%b an=%b x=%0d y=%0d fr=%0d",
               name, $time, got.stb, got.hs, got.vs, got.active, got.se, got.an, got.x, got.y, got.frame,
               exp.stb, exp.hs, exp.vs, exp.active, exp.se, exp.an, exp.x, exp.y, exp.frame);
    end
  endtask

  task automatic check_int(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) n_edge = 0;
    else n_edge = n_edge + 1;
    qa.push_back(model(n_edge, INC_A));
    qb.push_back(model(n_edge, INC_B));
  end

  always @(negedge clk) begin
    if (qa.size() > 0) check_obs("obs_a", got_a, qa.pop_front());
    if (qb.size() > 0) check_obs("obs_b", got_b, qb.pop_front());
    if (rst_n && a_se) se_cnt++;
    if (rst_n && a_an) an_cnt++;
  end

  initial begin
    obs_t e;
    bit found;
    int se0, b_cnt;
    longint frame_exp3, frame_exp_end;
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_exp3 = 3;
    frame_exp_end = 409;
`else
    frame_exp3 = 0;
    frame_exp_end = 0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    check_int("first_x", a_x, 0);
    check_int("first_y", a_y, 0);
    check_int("first_active", a_active, 1);
    repeat (3 * FRAME - 1) @(negedge clk);
    #1;
    check_int("frame_after_3", a_frame, frame_exp3);
    check_int("screenend_3_frames", se_cnt, 3);
    check_int("animate_3_frames", an_cnt, 3);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      e = model(n_edge, INC_A);
      if (e.x == 11'd5 && e.y == 11'd3) found = 1'b1;
    end
    check_int("reach_mid_frame", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_obs("async_reset_a", got_a, model(0, INC_A));
    check_obs("async_reset_b", got_b, model(0, INC_B));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    se0 = se_cnt;

    @(negedge clk);
    check_int("restart_x", a_x, 0);
    check_int("restart_y", a_y, 0);
    b_cnt = int'(b_stb);
    repeat (65535) begin
      @(negedge clk);
      b_cnt += int'(b_stb);
    end
    check_int("b_strobe_count", b_cnt, 42598);
    check_int("screenend_count", se_cnt - se0, 409);
    #1;
    check_int("frame_end", a_frame, frame_exp_end);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
